fetch_sequencer: RTL and testbench

Drives the program counter into the combinational instruction memory (pc in, 16-bit instruction out, same cycle) and buffers fetched instructions in a small queue for the decode stage.
Handles sequential fetch, branch/jump redirects, back-pressure from decode and HALT detection.
Sits between the instruction memory and decode in the 16-bit RISC core.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_sequencer.sv | 97 +++++++++
 tb/tb_fetch_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch sequencer.
package fetch_pkg;
  localparam int INSTR_W = 16;
  localparam int PC_W = 16;
  localparam int PC_STEP_DEF = 2;
  localparam int QDEPTH_DEF = 2;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0000;
  localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

  typedef enum logic {
    RUN = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries; flush beats push.
import fetch_pkg::*;

module fetch_queue #(
  parameter int DEPTH = QDEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic do_pop;
  logic do_push;

  assign empty = (count == '0);
  assign full = (count == FULL_CNT);
  assign dout = mem[head];
  assign do_pop = pop & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= din;
        tail <= tail + 1'b1;
      end
      if (do_pop) head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer + fetch queue. Define FETCH_PERF_EN for
// fetch/stall performance counters.
import fetch_pkg::*;

module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter int PC_STEP = PC_STEP_DEF,
  parameter int QDEPTH = QDEPTH_DEF,
  parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_pc,
  input  logic [15:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_stall_cnt
`endif
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QD = CW'(QDEPTH);
  localparam logic [15:0] STEP = 16'(PC_STEP);

  fetch_state_t state;
  logic [15:0] pc;
  logic pop;
  logic push;
  logic q_empty;
  logic q_full;
  logic [CW-1:0] q_count;
  fetch_entry_t q_din;
  fetch_entry_t q_dout;

  assign imem_pc = pc;
  assign halted = (state == HALTED);
  assign out_valid = ~q_empty;
  assign out_pc = q_dout.pc;
  assign out_instr = q_dout.instr;
  assign pop = out_valid & out_ready;
  assign push = (state == RUN) & ~redirect_valid
              & ((q_count < QD) | pop);
  assign q_din = '{pc: pc, instr: imem_instr};

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      state <= RUN;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      state <= RUN;
    end else if (push) begin
      pc <= pc + STEP;
      if (imem_instr[15:12] == HALT_OPCODE) state <= HALTED;
    end
  end

`ifdef FETCH_PERF_EN
  logic stall;
  assign stall = (state == RUN) & ~push & ~redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push && perf_fetch_cnt != 16'hFFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (stall && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

  logic unused_full;
  assign unused_full = q_full;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + random bench for fetch_sequencer against a queue model.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  logic [15:0] mem [32768];
  assign imem_instr = mem[imem_pc[15:1]];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t q[$];
  logic [15:0] m_pc;
  bit m_halted;
  int m_fetch;
  int m_stall;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("out_pc", {16'b0, out_pc}, {16'b0, q[0].pc});
      chk("out_instr", {16'b0, out_instr}, {16'b0, q[0].instr});
    end
    chk("imem_pc", {16'b0, imem_pc}, {16'b0, m_pc});
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
`ifdef FETCH_PERF_EN
    chk("perf_fetch", {16'b0, perf_fetch_cnt}, 32'(m_fetch));
    chk("perf_stall", {16'b0, perf_stall_cnt}, 32'(m_stall));
`endif
  endtask

  // Asserts reset between clock edges and checks it takes effect at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_pc", {16'b0, out_pc}, 32'h0);
    chk("rst_out_instr", {16'b0, out_instr}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_imem_pc", {16'b0, imem_pc}, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetch", {16'b0, perf_fetch_cnt}, 32'h0);
    chk("rst_perf_stall", {16'b0, perf_stall_cnt}, 32'h0);
`endif
    q.delete();
    m_pc = 16'h0000;
    m_halted = 0;
    m_fetch = 0;
    m_stall = 0;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic cycle(input logic rdy, input logic rv,
                       input logic [15:0] rpc);
    bit pop;
    bit push;
    ent_t e;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    pop = (q.size() != 0) && rdy;
    push = !m_halted && !rv && (q.size() < 2 || pop);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      e.pc = m_pc;
      e.instr = mem[m_pc[15:1]];
      q.push_back(e);
      m_pc = m_pc + 16'd2;
      if (e.instr[15:12] == 4'hF) m_halted = 1;
      if (m_fetch < 65535) m_fetch++;
    end else if (!m_halted && !rv) begin
      if (m_stall < 65535) m_stall++;
    end
    if (rv) begin
      q.delete();
      m_pc = rpc;
      m_halted = 0;
    end
    #1 check_all();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1001;
    mem[1] = 16'h1002;
    mem[2] = 16'h1003;
    mem[3] = 16'h2004;
    for (int i = 4; i < 24; i++) mem[i] = 16'h3000 | 16'(i);
    mem[32767] = 16'h1234;

    // sequential fetch with decode always ready
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);

    // back-pressure then release
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);
    chk("stall_imem_pc", {16'b0, imem_pc}, 32'h0004);
    chk("stall_head", {16'b0, out_instr}, 32'h1001);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);

    // redirect while full
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 16'h0020);
    chk("redir_empty", {31'b0, out_valid}, 32'h0);
    chk("redir_pc", {16'b0, imem_pc}, 32'h0020);
    cycle(1'b1, 1'b0, '0);
    chk("redir_out_pc", {16'b0, out_pc}, 32'h0020);
    cycle(1'b1, 1'b0, '0);

    // HALT at 0x0006, drain, then redirect restart
    mem[3] = 16'hF000;
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0);
    chk("halt_pc", {16'b0, imem_pc}, 32'h0008);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    cycle(1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);

    // pc wraps 0xFFFE -> 0x0000
    cycle(1'b1, 1'b1, 16'hFFFE);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);

    // async reset mid-stream
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0);
    do_reset();
    mem[3] = 16'h2004;

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 19) == 0),
            16'($urandom) & 16'hFFFE);
      if (i == 300) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
